// File: rtl/serial_loader.sv
// rtl/serial_loader.sv - framed byte-stream loader writing a payload into Z80 memory
//
// Frame: SYNC, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, LEN data bytes [, CSUM]
// Optional feature macro: SERIAL_LOADER_CHECKSUM_EN (adds the trailing CSUM byte check)
//
// Parameters:
//   TIMEOUT   inter-byte gap limit in clocks (1..65535)
//   SYNC      frame start byte
// Ports:
//   clk12     system clock
//   reset     asynchronous active-high reset
//   rx_byte   received byte, valid while rx_ready is high
//   rx_ready  1-cycle strobe per received byte
//   mem_addr  write address (held until the next write)
//   mem_data  write data (held until the next write)
//   mem_we    1-cycle write strobe
//   cpu_hold  Z80 reset request, high while a frame is in progress
//   load_ok   1-cycle pulse, frame accepted
//   load_err  1-cycle pulse, frame aborted (timeout or checksum mismatch)
module serial_loader #(
   parameter int unsigned TIMEOUT = 24000,
   parameter logic [7:0]  SYNC    = 8'hA5
) (
   input  logic        clk12,
   input  logic        reset,
   input  logic [7:0]  rx_byte,
   input  logic        rx_ready,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_data,
   output logic        mem_we,
   output logic        cpu_hold,
   output logic        load_ok,
   output logic        load_err
);

   localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

   typedef enum logic [2:0] {
      IDLE, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, DATA
`ifdef SERIAL_LOADER_CHECKSUM_EN
      , CSUM
`endif
   } state_t;

   state_t      state, state_n;
   logic [15:0] addr, addr_n;
   logic [15:0] len, len_n;
   logic [15:0] gap, gap_n;
   logic [15:0] gap_inc;
   logic [15:0] mem_addr_n;
   logic [7:0]  mem_data_n;
   logic        we_n, hold_n, ok_n, err_n;
   logic        last;
`ifdef SERIAL_LOADER_CHECKSUM_EN
   logic [7:0]  sum, sum_n;
`endif

   assign gap_inc = gap + 16'd1;

   always_ff @(posedge clk12 or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         addr     <= '0;
         len      <= '0;
         gap      <= '0;
         mem_addr <= '0;
         mem_data <= '0;
         mem_we   <= 1'b0;
         cpu_hold <= 1'b0;
         load_ok  <= 1'b0;
         load_err <= 1'b0;
`ifdef SERIAL_LOADER_CHECKSUM_EN
         sum      <= '0;
`endif
      end else begin
         state    <= state_n;
         addr     <= addr_n;
         len      <= len_n;
         gap      <= gap_n;
         mem_addr <= mem_addr_n;
         mem_data <= mem_data_n;
         mem_we   <= we_n;
         cpu_hold <= hold_n;
         load_ok  <= ok_n;
         load_err <= err_n;
`ifdef SERIAL_LOADER_CHECKSUM_EN
         sum      <= sum_n;
`endif
      end
   end

   always_comb begin
      state_n    = state;
      addr_n     = addr;
      len_n      = len;
      gap_n      = gap;
      mem_addr_n = mem_addr;
      mem_data_n = mem_data;
      we_n       = 1'b0;
      hold_n     = cpu_hold;
      ok_n       = 1'b0;
      err_n      = 1'b0;
      last       = 1'b0;
`ifdef SERIAL_LOADER_CHECKSUM_EN
      sum_n      = sum;
`endif

      if (rx_ready) begin
         // A byte always clears the gap counter, even if the limit is hit this cycle.
         gap_n = '0;
         case (state)
            IDLE: begin
               if (rx_byte == SYNC) begin
                  state_n = ADDR_LO;
                  hold_n  = 1'b1;
`ifdef SERIAL_LOADER_CHECKSUM_EN
                  sum_n   = '0;
`endif
               end
            end
            ADDR_LO: begin
               addr_n[7:0] = rx_byte;
               state_n     = ADDR_HI;
            end
            ADDR_HI: begin
               addr_n[15:8] = rx_byte;
               state_n      = LEN_LO;
            end
            LEN_LO: begin
               len_n[7:0] = rx_byte;
               state_n    = LEN_HI;
            end
            LEN_HI: begin
               len_n[15:8] = rx_byte;
               if ({rx_byte, len[7:0]} == 16'd0) begin
                  last = 1'b1;
               end else begin
                  state_n = DATA;
               end
            end
            DATA: begin
               we_n       = 1'b1;
               mem_addr_n = addr;
               mem_data_n = rx_byte;
               addr_n     = addr + 16'd1;
               len_n      = len - 16'd1;
`ifdef SERIAL_LOADER_CHECKSUM_EN
               sum_n      = sum + rx_byte;
`endif
               if (len == 16'd1) begin
                  last = 1'b1;
               end
            end
`ifdef SERIAL_LOADER_CHECKSUM_EN
            CSUM: begin
               if (rx_byte == sum) begin
                  ok_n = 1'b1;
               end else begin
                  err_n = 1'b1;
               end
               hold_n  = 1'b0;
               state_n = IDLE;
            end
`endif
            default: begin
               state_n = IDLE;
            end
         endcase

         // End of header/payload: either wait for the checksum or finish now.
         if (last) begin
`ifdef SERIAL_LOADER_CHECKSUM_EN
            state_n = CSUM;
`else
            ok_n    = 1'b1;
            hold_n  = 1'b0;
            state_n = IDLE;
`endif
         end
      end else if (state != IDLE) begin
         if (gap_inc == TIMEOUT_CNT) begin
            err_n   = 1'b1;
            hold_n  = 1'b0;
            state_n = IDLE;
            gap_n   = '0;
         end else begin
            gap_n = gap_inc;
         end
      end
   end

endmodule
